wrr_hold_arbt: RTL and testbench

//  Weighted round-robin arbiter that shares one multi-cycle resource (bus/port) among N requesters.
//  A grant is held from issue until the resource signals done, the holder drops req, or a hold

---
 rtl/wrr_hold_arbt.sv | 195 +++++++++++++++++++
 tb/tb_wrr_hold_arbt.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_hold_arbt.sv
// wrr_hold_arbt: weighted round-robin arbiter for one multi-cycle resource.
// A grant is held until done, until the holder drops req, or until the hold timeout fires.
// Ports:
//   clk, rst_n  - clock and async active-low reset
//   req[N]      - level request per agent
//   done        - 1-cycle pulse, resource finished the current transfer
//   weight_cfg  - agent i weight at [i*WW +: WW], 0 treated as 1
//   gnt[N]      - registered one-hot grant
//   gnt_vld     - any grant active
//   gnt_id      - index of last holder (sticky while gnt_vld=0)
//   timeout     - 1-cycle pulse when a grant is force-released
module wrr_hold_arbt #(
    parameter int N        = 4,
    parameter int WW       = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    input  logic [N*WW-1:0]      weight_cfg,
    output logic [N-1:0]         gnt,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_GRANT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nxt_state;
    logic [WW-1:0]   r_credit [N];
    logic [WW-1:0]   w_credit [N];
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr;
    logic [IW-1:0]   r_gnt_id;
    logic [IW-1:0]   w_gnt_id;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_cnt;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt;
    logic            r_timeout;
    logic            w_timeout;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_cand;
    logic            w_in_grant;
    logic            w_done;
    logic            w_abandon;
    logic            w_expire;
    logic            w_release;

    function automatic logic [IW-1:0] f_wrap(input int v);
        return IW'(v % N);
    endfunction

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] idx);
        return (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First agent with a request and credit left, scanning from r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = f_wrap(int'(r_ptr) + k);
            if (!w_found && req[w_cand] && (r_credit[w_cand] != '0)) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Release causes in priority order: done, then abandon, then timeout.
    assign w_in_grant = (r_state == S_GRANT);
    assign w_done     = w_in_grant && done;
    assign w_abandon  = w_in_grant && !done && !req[r_gnt_id];
    assign w_expire   = w_in_grant && !done && req[r_gnt_id] &&
                        (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_release  = w_done || w_abandon || w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nxt_state = S_GRANT;
                end else if (|req) begin
                    w_nxt_state = S_REFILL;
                end
            end
            S_REFILL: w_nxt_state = S_IDLE;
            S_GRANT: begin
                if (w_release) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt      = r_gnt;
        w_gnt_id   = r_gnt_id;
        w_ptr      = r_ptr;
        w_hold_cnt = r_hold_cnt;
        w_timeout  = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_credit[i] = r_credit[i];
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt        = '0;
                    w_gnt[w_win] = 1'b1;
                    w_gnt_id     = w_win;
                    w_hold_cnt   = '0;
                end
            end
            S_REFILL: begin
                for (int i = 0; i < N; i++) begin
                    if (weight_cfg[i*WW +: WW] == '0) begin
                        w_credit[i] = WW'(1);
                    end else begin
                        w_credit[i] = weight_cfg[i*WW +: WW];
                    end
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_gnt = '0;
                    w_ptr = f_inc(r_gnt_id);
                    if (w_done) begin
                        if (r_credit[r_gnt_id] != '0) begin
                            w_credit[r_gnt_id] = r_credit[r_gnt_id] - 1'b1;
                        end
                    end else if (w_expire) begin
                        w_credit[r_gnt_id] = '0;
                        w_timeout          = 1'b1;
                    end
                end else if (r_hold_cnt != '1) begin
                    w_hold_cnt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_credit[i] <= '0;
            end
        end else begin
            r_gnt      <= w_gnt;
            r_gnt_id   <= w_gnt_id;
            r_ptr      <= w_ptr;
            r_hold_cnt <= w_hold_cnt;
            r_timeout  <= w_timeout;
            for (int i = 0; i < N; i++) begin
                r_credit[i] <= w_credit[i];
            end
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = |r_gnt;
    assign gnt_id  = r_gnt_id;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_wrr_hold_arbt.sv
// tb_wrr_hold_arbt: directed scenarios plus random traffic for wrr_hold_arbt,
// compared each cycle against a holder/credit model of the arbitration rules.
module tb_wrr_hold_arbt;

    localparam int N     = 4;
    localparam int WW    = 4;
    localparam int MAXH  = 8;
    localparam int WBITS = N * WW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             done;
    logic [WBITS-1:0] weight_cfg;
    logic [N-1:0]     gnt;
    logic             gnt_vld;
    logic [1:0]       gnt_id;
    logic             timeout;

    int n_chk = 0;
    int n_err = 0;

    // model state: current holder (-1 = none), cycles held, credits
    int m_hold   = -1;
    int m_age    = 0;
    int m_ptr    = 0;
    int m_last   = 0;
    int m_cred [N];
    int m_w;
    int m_a;
    bit m_refill = 1'b0;
    bit m_to     = 1'b0;

    int q_ord [$];
    int q_gap [$];
    int q_hi  [$];
    int low_run  = 0;
    int hi_run   = 0;
    int n_to     = 0;
    bit prev_vld = 1'b0;

    int dmode = 0;
    int d_at  = 2;
    int lat;

    int e1 [10];
    int g1 [7];
    int e2 [14];
    int e3 [4];
    int e4 [7];
    int e5 [3];

    always #5 clk = ~clk;

    wrr_hold_arbt #(
        .N        (N),
        .WW       (WW),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .weight_cfg (weight_cfg),
        .gnt        (gnt),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id),
        .timeout    (timeout)
    );

    task automatic check(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp_v, $time);
        end
    endtask

    function automatic int qv(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -99;
    endfunction

    function automatic logic [N-1:0] f_exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_hold >= 0) g[m_hold] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_hold   = -1;
        m_age    = 0;
        m_ptr    = 0;
        m_last   = 0;
        m_refill = 1'b0;
        m_to     = 1'b0;
        for (int i = 0; i < N; i++) m_cred[i] = 0;
    endtask

    task automatic model_release();
        m_ptr  = (m_hold + 1) % N;
        m_hold = -1;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_hold >= 0) begin
            if (done) begin
                if (m_cred[m_hold] > 0) m_cred[m_hold] = m_cred[m_hold] - 1;
                model_release();
            end else if (!req[m_hold]) begin
                model_release();
            end else if (MAXH != 0 && m_age == MAXH) begin
                m_cred[m_hold] = 0;
                m_to = 1'b1;
                model_release();
            end else begin
                m_age++;
            end
        end else if (m_refill) begin
            for (int i = 0; i < N; i++) begin
                m_w = int'(weight_cfg[i*WW +: WW]);
                m_cred[i] = (m_w == 0) ? 1 : m_w;
            end
            m_refill = 1'b0;
        end else if (req != '0) begin
            m_w = -1;
            for (int k = 0; k < N; k++) begin
                m_a = (m_ptr + k) % N;
                if (m_w < 0 && req[m_a] && m_cred[m_a] > 0) m_w = m_a;
            end
            if (m_w >= 0) begin
                m_hold = m_w;
                m_last = m_w;
                m_age  = 1;
                q_ord.push_back(m_w);
            end else begin
                m_refill = 1'b1;
                q_ord.push_back(-1);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic cmp_cycle();
        check("gnt", int'(gnt), int'(f_exp_gnt()));
        check("gnt_vld", int'(gnt_vld), int'(m_hold >= 0));
        check("gnt_id", int'(gnt_id), m_last);
        check("timeout", int'(timeout), int'(m_to));
        if (!rst_n) begin
            low_run  = 0;
            hi_run   = 0;
            prev_vld = 1'b0;
        end else begin
            if (timeout) n_to++;
            if (gnt_vld) begin
                if (!prev_vld) q_gap.push_back(low_run);
                low_run = 0;
                hi_run++;
            end else begin
                if (prev_vld) q_hi.push_back(hi_run);
                hi_run = 0;
                low_run++;
            end
            prev_vld = gnt_vld;
        end
    endtask

    always @(negedge clk) cmp_cycle();

    // done responder: 0 off, 1 on a given held cycle, 2 random
    task automatic drive_done();
        case (dmode)
            0: done = 1'b0;
            1: done = (m_hold >= 0 && m_age == d_at);
            default: done = ($urandom_range(0, 5) == 0);
        endcase
    endtask

    always @(posedge clk) begin
        #2;
        drive_done();
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        dmode = 0;
        req   = '0;
        #1;
        check("rst_gnt", int'(gnt), 0);
        check("rst_vld", int'(gnt_vld), 0);
        check("rst_id", int'(gnt_id), 0);
        check("rst_to", int'(timeout), 0);
        repeat (2) @(posedge clk);
        #2;
        q_ord.delete();
        q_gap.delete();
        q_hi.delete();
        n_to  = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_ord(input int n, input int budget, input string nm);
        for (int k = 0; k < budget && q_ord.size() < n; k++) begin
            @(posedge clk);
        end
        check(nm, int'(q_ord.size() >= n), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_hold(input int h, input int age,
                             input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(posedge clk);
            #2;
            if (m_hold == h && m_age == age) hit = 1'b1;
        end
        check(nm, int'(hit), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        e1 = '{-1, 0, 1, 2, 3, -1, 0, 1, 2, 3};
        g1 = '{1, 1, 1, 3, 1, 1, 1};
        e2 = '{-1, 0, 1, 2, 3, 0, 0, -1, 1, 2, 3, 0, 0, 0};
        e3 = '{-1, 0, -1, 0};
        e4 = '{-1, 2, 3, 0, 1, 2, -1};
        e5 = '{-1, 1, 1};
        rst_n      = 1'b0;
        req        = '0;
        weight_cfg = 16'h1111;
        do_reset();

        // equal weights, done on second held cycle
        weight_cfg = 16'h1111;
        d_at  = 2;
        dmode = 1;
        req   = 4'b1111;
        wait_ord(10, 200, "t1_wait");
        for (int i = 0; i < 10; i++) check("t1_order", qv(q_ord, i), e1[i]);
        for (int i = 0; i < 7; i++) check("t1_gap", qv(q_gap, i + 1), g1[i]);

        // agent 0 weight 3
        do_reset();
        weight_cfg = 16'h1113;
        d_at  = 2;
        dmode = 1;
        req   = 4'b1111;
        wait_ord(14, 300, "t2_wait");
        for (int i = 0; i < 14; i++) check("t2_order", qv(q_ord, i), e2[i]);

        // timeout on a lone holder
        do_reset();
        weight_cfg = 16'h1111;
        req = 4'b0001;
        wait_ord(4, 100, "t3_wait");
        for (int i = 0; i < 4; i++) check("t3_order", qv(q_ord, i), e3[i]);
        check("t3_hold_len", qv(q_hi, 0), 8);
        check("t3_regap", qv(q_gap, 1), 3);
        check("t3_to_count", n_to, 1);

        // abandon by agent 2
        do_reset();
        weight_cfg = 16'h1111;
        req = 4'b0100;
        wait_hold(2, 2, 30, "t4_hold");
        req = '0;
        repeat (3) @(posedge clk);
        #2;
        check("t4_hold_len", qv(q_hi, 0), 2);
        check("t4_no_to", n_to, 0);
        d_at  = 2;
        dmode = 1;
        req   = 4'b1111;
        wait_ord(7, 200, "t4_wait");
        for (int i = 0; i < 7; i++) check("t4_order", qv(q_ord, i), e4[i]);

        // done, abandon and timeout on the same edge
        do_reset();
        weight_cfg = 16'h1121;
        d_at  = MAXH;
        dmode = 1;
        req   = 4'b0010;
        wait_hold(1, MAXH, 40, "t5_hold");
        req = '0;
        repeat (2) @(posedge clk);
        #2;
        dmode = 0;
        req   = 4'b0010;
        wait_ord(3, 50, "t5_wait");
        for (int i = 0; i < 3; i++) check("t5_order", qv(q_ord, i), e5[i]);
        check("t5_no_to", n_to, 0);

        // async reset while agent 1 holds
        do_reset();
        weight_cfg = 16'h1111;
        req = 4'b0010;
        wait_hold(1, 3, 30, "t6_hold");
        rst_n = 1'b0;
        #1;
        check("t6_gnt_drop", int'(gnt), 0);
        check("t6_vld_drop", int'(gnt_vld), 0);
        check("t6_no_to", int'(timeout), 0);
        req = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        req = 4'b0010;
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (gnt == 4'b0010) lat = k;
        end
        check("t6_latency", lat, 3);

        // random traffic
        do_reset();
        dmode      = 2;
        weight_cfg = WBITS'($urandom);
        req        = N'($urandom);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 31) == 0) weight_cfg = WBITS'($urandom);
        end
        dmode = 0;
        req   = '0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
